// File: rtl/sdrd_sector_buf.sv
// rtl/sdrd_sector_buf.sv - SD reader sector capture buffer
// Purpose: accepts a sector-read request, drives the SD reader core's
//   rstart/rsector handshake, packs the core's byte stream little-endian
//   into 32-bit words and stores them in a 128x32 buffer for the ICB slave.
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   rd_req, rd_sector    request pulse and sector number from register side
//   busy, done, err      status (done/err sticky until next accepted request)
//   byte_cnt             bytes captured in current/last read (0..512)
//   rstart, rsector      read request level and sector number to the core
//   rbusy, rdone         core progress and completion pulse
//   outen/outaddr/outbyte  core byte stream
//   buf_raddr, buf_rdata word read port, 1-cycle registered latency
module sdrd_sector_buf #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [31:0] rd_sector,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [9:0]  byte_cnt,
  output logic        rstart,
  output logic [31:0] rsector,
  input  logic        rbusy,
  input  logic        rdone,
  input  logic        outen,
  input  logic [8:0]  outaddr,
  input  logic [7:0]  outbyte,
  input  logic [6:0]  buf_raddr,
  output logic [31:0] buf_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_FILL} state_t;

  localparam logic [31:0] TMO_LAST = TIMEOUT - 32'd1;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rstart_q, rstart_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] rsector_q, rsector_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [23:0] pack_q, pack_d;
  logic [31:0] buf_rdata_q, buf_rdata_d;

  logic [31:0] mem [128];
  logic        mem_we;
  logic [6:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        byte_ok;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    rstart_d    = rstart_q;
    byte_cnt_d  = byte_cnt_q;
    rsector_d   = rsector_q;
    tmo_cnt_d   = tmo_cnt_q;
    pack_d      = pack_q;
    mem_we      = 1'b0;
    mem_waddr   = outaddr[8:2];
    mem_wdata   = {outbyte, pack_q};
    // Bytes must arrive strictly in order and never beyond one sector.
    byte_ok     = (outaddr == byte_cnt_q[8:0]) && (byte_cnt_q < 10'd512);
    // Plain array read: the registered copy sees the pre-write contents.
    buf_rdata_d = mem[buf_raddr];

    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          rsector_d  = rd_sector;
          done_d     = 1'b0;
          err_d      = 1'b0;
          byte_cnt_d = 10'd0;
          busy_d     = 1'b1;
          rstart_d   = 1'b1;
          tmo_cnt_d  = 32'd0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (rbusy) begin
          rstart_d = 1'b0;
          state_d  = ST_FILL;
        end else if ((TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST)) begin
          // rstart has been high for exactly TIMEOUT cycles.
          err_d    = 1'b1;
          busy_d   = 1'b0;
          rstart_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
      end
      ST_FILL: begin
        if (outen) begin
          if (byte_ok) begin
            byte_cnt_d = byte_cnt_q + 10'd1;
            case (outaddr[1:0])
              2'd0:    pack_d[7:0]   = outbyte;
              2'd1:    pack_d[15:8]  = outbyte;
              2'd2:    pack_d[23:16] = outbyte;
              default: mem_we        = 1'b1;
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
        // Completion uses the count/error including a same-cycle byte.
        if (rdone) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          if ((byte_cnt_d == 10'd512) && !err_d) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rstart_q    <= 1'b0;
      byte_cnt_q  <= 10'd0;
      rsector_q   <= 32'd0;
      tmo_cnt_q   <= 32'd0;
      pack_q      <= 24'd0;
      buf_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rstart_q    <= rstart_d;
      byte_cnt_q  <= byte_cnt_d;
      rsector_q   <= rsector_d;
      tmo_cnt_q   <= tmo_cnt_d;
      pack_q      <= pack_d;
      buf_rdata_q <= buf_rdata_d;
    end
  end

  // Buffer storage has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign byte_cnt  = byte_cnt_q;
  assign rstart    = rstart_q;
  assign rsector   = rsector_q;
  assign buf_rdata = buf_rdata_q;

endmodule

// File: tb/tb_sdrd_sector_buf.sv
// tb/tb_sdrd_sector_buf.sv - self-checking bench for sdrd_sector_buf
module tb_sdrd_sector_buf;

  logic        clk = 1'b0;
  logic        rst, rd_req, rbusy, rdone, outen;
  logic [31:0] rd_sector;
  logic        busy, done, err, rstart;
  logic [9:0]  byte_cnt;
  logic [31:0] rsector, buf_rdata;
  logic [8:0]  outaddr;
  logic [7:0]  outbyte;
  logic [6:0]  buf_raddr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdrd_sector_buf #(.TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_sector(rd_sector),
    .busy(busy), .done(done), .err(err), .byte_cnt(byte_cnt),
    .rstart(rstart), .rsector(rsector), .rbusy(rbusy), .rdone(rdone),
    .outen(outen), .outaddr(outaddr), .outbyte(outbyte),
    .buf_raddr(buf_raddr), .buf_rdata(buf_rdata)
  );

  typedef struct {
    logic [6:0]  raddr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] sec);
    rd_req = 1'b1;
    rd_sector = sec;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic core_go();
    rbusy = 1'b1;
    tick();
  endtask

  task automatic send_byte(input int i, input logic [7:0] pat);
    outen = 1'b1;
    outaddr = 9'(i);
    outbyte = 8'(i) ^ pat;
    tick();
    outen = 1'b0;
  endtask

  task automatic core_done();
    rdone = 1'b1;
    tick();
    rdone = 1'b0;
    rbusy = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0] = '{7'd0,   32'h03020100};
    vecs[1] = '{7'd1,   32'h07060504};
    vecs[2] = '{7'd2,   32'h0B0A0908};
    vecs[3] = '{7'd63,  32'hFFFEFDFC};
    vecs[4] = '{7'd64,  32'h03020100};
    vecs[5] = '{7'd100, 32'h93929190};
    vecs[6] = '{7'd127, 32'hFFFEFDFC};

    rst = 1'b1; rd_req = 1'b0; rd_sector = 32'd0; rbusy = 1'b0; rdone = 1'b0;
    outen = 1'b0; outaddr = 9'd0; outbyte = 8'd0; buf_raddr = 7'd0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rstart", 32'(rstart), 32'd0);
    check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    check("rst_rsector", rsector, 32'd0);
    check("rst_buf_rdata", buf_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // 1: full sector read
    request(32'h1234);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_rstart", 32'(rstart), 32'd1);
    core_go();
    check("t1_rstart_drop", 32'(rstart), 32'd0);
    for (int i = 0; i < 512; i++) send_byte(i, 8'h00);
    core_done();
    check("t1_rsector", rsector, 32'h1234);
    check("t1_done", 32'(done), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_byte_cnt", 32'(byte_cnt), 32'd512);
    for (int v = 0; v < 7; v++) begin
      buf_raddr = vecs[v].raddr;
      tick();
      check($sformatf("t1_buf[%0d]", vecs[v].raddr), buf_rdata, vecs[v].exp);
    end

    // 2: core never raises rbusy
    request(32'hABCD);
    n = 0;
    while (rstart === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    check("t2_rstart_cycles", 32'(n), 32'd100);
    check("t2_err", 32'(err), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_rstart", 32'(rstart), 32'd0);
    check("t2_done", 32'(done), 32'd0);

    // 3: core skips outaddr=5
    request(32'h0000_0042);
    check("t3_err_cleared", 32'(err), 32'd0);
    core_go();
    for (int i = 0; i < 512; i++) if (i != 5) send_byte(i, 8'h00);
    core_done();
    check("t3_err", 32'(err), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    check("t3_byte_cnt", 32'(byte_cnt), 32'd5);
    check("t3_busy", 32'(busy), 32'd0);

    // 4: second request during FILL, short sector
    request(32'h77);
    core_go();
    for (int i = 0; i < 128; i++) send_byte(i, 8'h00);
    request(32'h99);
    check("t4_busy_mid", 32'(busy), 32'd1);
    check("t4_err_mid", 32'(err), 32'd0);
    check("t4_rsector_mid", rsector, 32'h77);
    for (int i = 128; i < 256; i++) send_byte(i, 8'h00);
    core_done();
    check("t4_rsector", rsector, 32'h77);
    check("t4_err", 32'(err), 32'd1);
    check("t4_done", 32'(done), 32'd0);
    check("t4_byte_cnt", 32'(byte_cnt), 32'd256);

    // 5: reset during FILL, then a normal read
    request(32'h55);
    core_go();
    for (int i = 0; i < 100; i++) send_byte(i, 8'h00);
    check("t5_cnt_pre", 32'(byte_cnt), 32'd100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rbusy = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_err", 32'(err), 32'd0);
    check("t5_byte_cnt", 32'(byte_cnt), 32'd0);
    check("t5_rstart", 32'(rstart), 32'd0);
    send_byte(0, 8'h00);
    check("t5_ignored_byte", 32'(byte_cnt), 32'd0);

    request(32'h5678);
    core_go();
    for (int i = 0; i < 511; i++) begin
      if (i == 15) begin
        // 6: read word 3 in the cycle it is written
        buf_raddr = 7'd3;
        send_byte(i, 8'hA5);
        check("t6_old_word", buf_rdata, 32'h0F0E0D0C);
        tick();
        check("t6_new_word", buf_rdata, 32'hAAABA8A9);
      end else begin
        send_byte(i, 8'hA5);
      end
    end
    // last byte arrives together with rdone
    outen = 1'b1; outaddr = 9'd511; outbyte = 8'hFF ^ 8'hA5; rdone = 1'b1;
    tick();
    outen = 1'b0; rdone = 1'b0; rbusy = 1'b0;
    check("t5_new_done", 32'(done), 32'd1);
    check("t5_new_err", 32'(err), 32'd0);
    check("t5_new_byte_cnt", 32'(byte_cnt), 32'd512);
    check("t5_new_rsector", rsector, 32'h5678);
    buf_raddr = 7'd127;
    tick();
    check("t5_buf127", buf_rdata, 32'h5A5B5859);
    buf_raddr = 7'd0;
    tick();
    check("t5_buf0", buf_rdata, 32'hA6A7A4A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
